// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Bit-serial sequencer around a single 1-bit ALU slice. Operands are captured
// on a start/ready handshake, fed to the slice LSB-first over WIDTH cycles,
// and the assembled WIDTH-bit result plus carry-out is offered on a
// valid/ready handshake.
//
// Optional feature: define ALU_ZERO_FLAG_EN to add zero_o, set when the final
// result is all zeros.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   start_i / ready_o       operand request handshake (ready_o high in IDLE)
//   op_a_i, op_b_i, cin_i   operands and carry-in, sampled on accept
//   sel_i                   op select; [3:2] 00 arith, 01 logic, 10 shr, 11 shl
//   slice_a_o .. slice_sel_o  drive to the 1-bit slice (zero outside RUN)
//   slice_f_i, slice_cout_i result bit and carry from the slice
//   result_o, cout_o        assembled result and final carry / shifted-out bit
//   valid_o / res_ready_i   result handshake; result held until consumed
//   zero_o                  (ALU_ZERO_FLAG_EN only) final result == 0
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_cin_o,
    output logic [3:0]       slice_sel_o,
    input  logic             slice_f_i,
    input  logic             slice_cout_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             valid_o,
    input  logic             res_ready_i
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             zero_o
`endif
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_a;       // A, shifted right one bit per RUN cycle
    logic [WIDTH-1:0] r_b;       // B, shifted right one bit per RUN cycle
    logic [3:0]       r_sel;
    logic             r_carry;
    logic [IdxW-1:0]  r_index;
    logic             r_prev_a;  // A bit of the previous cycle, feeds shl
    logic             r_shout;   // bit shifted out by a shift op
    logic [WIDTH-2:0] r_shadow;  // result bits collected so far, filled from MSB
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_is_shift;
    logic             w_bit;
    logic [WIDTH-1:0] w_assembled;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start_i)     w_state_next = StRun;
            StRun:   if (w_last)      w_state_next = StDone;
            StDone:  if (res_ready_i) w_state_next = StIdle;
            default:                  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_run       = (r_state == StRun);
        w_accept    = (r_state == StIdle) && start_i;
        w_last      = w_run && (r_index == LastIdx);
        w_is_shift  = r_sel[3];
        // shr takes A[i+1] (zero-filled by the right shift of r_a at the top),
        // shl takes A[i-1] (r_prev_a starts at 0 for bit 0).
        if (w_is_shift) begin
            w_bit = r_sel[2] ? r_prev_a : r_a[1];
        end else begin
            w_bit = slice_f_i;
        end
        w_assembled = {w_bit, r_shadow};

        ready_o     = (r_state == StIdle);
        valid_o     = (r_state == StDone);
        slice_a_o   = w_run & r_a[0];
        slice_b_o   = w_run & r_b[0];
        slice_cin_o = w_run & r_carry;
        slice_sel_o = w_run ? r_sel : 4'b0000;
        result_o    = r_result;
        cout_o      = r_cout;
    end

    // ------------------------------------------------------------------
    // Operand shift registers, carry and bit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_carry  <= 1'b0;
            r_index  <= '0;
            r_prev_a <= 1'b0;
            r_shout  <= 1'b0;
        end else if (w_accept) begin
            r_a      <= op_a_i;
            r_b      <= op_b_i;
            r_sel    <= sel_i;
            r_carry  <= cin_i;
            r_index  <= '0;
            r_prev_a <= 1'b0;
            r_shout  <= sel_i[2] ? op_a_i[WIDTH-1] : op_a_i[0];
        end else if (w_run) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_carry  <= slice_cout_i;
            r_index  <= w_last ? '0 : r_index + 1'b1;
            r_prev_a <= r_a[0];
        end
    end

    // ------------------------------------------------------------------
    // Result assembly; result_o only changes on the RUN->DONE edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shadow <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (w_run) begin
            r_shadow <= w_assembled[WIDTH-1:1];
            if (w_last) begin
                r_result <= w_assembled;
                r_cout   <= w_is_shift ? r_shout : slice_cout_i;
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    // Sticky OR of captured bits avoids a WIDTH-wide compare.
    logic r_nonzero;
    logic r_zero;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_nonzero <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_accept) begin
            r_nonzero <= 1'b0;
        end else if (w_run) begin
            r_nonzero <= r_nonzero | w_bit;
            if (w_last) begin
                r_zero <= ~(r_nonzero | w_bit);
            end
        end
    end

    assign zero_o = r_zero;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         cin_i = 1'b0;
    logic [3:0]   sel_i = 4'b0000;
    logic         slice_a_o, slice_b_o, slice_cin_o;
    logic [3:0]   slice_sel_o;
    logic         slice_f_i, slice_cout_i;
    logic [W-1:0] result_o;
    logic         cout_o, valid_o;
    logic         res_ready_i = 1'b0;
`ifdef ALU_ZERO_FLAG_EN
    logic         zero_o;
`endif

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .cin_i        (cin_i),
        .sel_i        (sel_i),
        .slice_a_o    (slice_a_o),
        .slice_b_o    (slice_b_o),
        .slice_cin_o  (slice_cin_o),
        .slice_sel_o  (slice_sel_o),
        .slice_f_i    (slice_f_i),
        .slice_cout_i (slice_cout_i),
        .result_o     (result_o),
        .cout_o       (cout_o),
        .valid_o      (valid_o),
        .res_ready_i  (res_ready_i)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_o       (zero_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rr_mode = 2;   // 0 random, 1 hold low, 2 hold high
    logic force_f = 1'b0;
    logic prev_valid = 1'b0;

    // Behavioural slice: arith (sel[0] inverts B), logic ops pass cin to cout
    logic m_f, m_c, m_bb;
    always_comb begin
        m_f  = 1'b0;
        m_c  = 1'b0;
        m_bb = slice_sel_o[0] ? ~slice_b_o : slice_b_o;
        case (slice_sel_o[3:2])
            2'b00: begin
                m_f = slice_a_o ^ m_bb ^ slice_cin_o;
                m_c = (slice_a_o & m_bb) | (slice_a_o & slice_cin_o) | (m_bb & slice_cin_o);
            end
            2'b01: begin
                case (slice_sel_o[1:0])
                    2'b00:   m_f = slice_a_o & slice_b_o;
                    2'b01:   m_f = slice_a_o | slice_b_o;
                    2'b10:   m_f = slice_a_o ^ slice_b_o;
                    default: m_f = ~(slice_a_o | slice_b_o);
                endcase
                m_c = slice_cin_o;
            end
            default: begin
                m_f = slice_a_o ^ slice_b_o;
                m_c = slice_cin_o;
            end
        endcase
    end
    assign slice_f_i    = m_f | force_f;
    assign slice_cout_i = m_c;

    // Word-level reference model
    function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic [3:0] sel);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] bb;
        e = '0;
        case (sel[3:2])
            2'b00: begin
                bb     = sel[0] ? ~b : b;
                s      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
                e.res  = s[W-1:0];
                e.cout = s[W];
            end
            2'b01: begin
                case (sel[1:0])
                    2'b00:   e.res = a & b;
                    2'b01:   e.res = a | b;
                    2'b10:   e.res = a ^ b;
                    default: e.res = ~(a | b);
                endcase
                e.cout = cin;
            end
            2'b10: begin
                e.res  = a >> 1;
                e.cout = a[0];
            end
            default: begin
                e.res  = a << 1;
                e.cout = a[W-1];
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc++;

    // Consumer-side ready generator
    always @(posedge clk) begin
        #2;
        case (rr_mode)
            0:       res_ready_i = ($urandom_range(0, 3) != 0);
            1:       res_ready_i = 1'b0;
            default: res_ready_i = 1'b1;
        endcase
    end

    // Monitor: latency on valid rise, result compare on consume
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (valid_o && !prev_valid) begin
            if (acc_q.size() == 0) fail("latency_noaccept");
            else begin
                a = acc_q.pop_front();
                chk("latency", 64'(cyc - a), 64'(W));
            end
        end
        if (valid_o && res_ready_i) begin
            if (exp_q.size() == 0) fail("unexpected_result");
            else begin
                e = exp_q.pop_front();
                chk("result", 64'(result_o), 64'(e.res));
                chk("cout", 64'(cout_o), 64'(e.cout));
`ifdef ALU_ZERO_FLAG_EN
                chk("zero", 64'(zero_o), 64'(e.zero));
`endif
            end
        end
        prev_valid = valid_o;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_o) fail("ready_timeout");
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [3:0] sel, input logic ff);
        wait_ready();
        force_f = ff;
        op_a_i  = a;
        op_b_i  = b;
        cin_i   = cin;
        sel_i   = sel;
        start_i = 1'b1;
        exp_q.push_back(ref_op(a, b, cin, sel));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        // Scramble inputs: they must have no effect after accept
        op_a_i  = $urandom;
        op_b_i  = $urandom;
        cin_i   = 1'($urandom);
        sel_i   = 4'($urandom);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_result"}, 64'(result_o), 64'd0);
        chk({tag, "_cout"}, 64'(cout_o), 64'd0);
        chk({tag, "_slice"}, 64'({slice_a_o, slice_b_o, slice_cin_o, slice_sel_o}), 64'd0);
    endtask

    initial begin
        exp_t         e;
        logic [63:0]  ca, cb, m;
        int           n;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
`ifdef ALU_ZERO_FLAG_EN
        chk("reset_zero", 64'(zero_o), 64'd0);
`endif
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Directed ops
        rr_mode = 2;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b0000, 1'b0);
        issue(32'h8000_0001, 32'h0000_0000, 1'b0, 4'b1000, 1'b0);
        issue(32'h8000_0001, 32'h0000_0000, 1'b0, 4'b1100, 1'b1);

        // Backpressure and start ignored in DONE
        wait_ready();
        rr_mode = 1;
        e = ref_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 4'b0001);
        issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 4'b0001, 1'b0);
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!valid_o) fail("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_result", 64'(result_o), 64'(e.res));
            chk("bp_cout", 64'(cout_o), 64'(e.cout));
            chk("bp_ready", 64'(ready_o), 64'd0);
            start_i = (i == 3);
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        rr_mode = 2;
        @(posedge clk);
        #1;
        chk("bp_release_ready", 64'(ready_o), 64'd1);
        chk("bp_release_valid", 64'(valid_o), 64'd0);
        chk("bp_retained", 64'(result_o), 64'(e.res));

        // Carry chaining: slice_cin_o per cycle
        issue(32'h0000_00FF, 32'h0000_0001, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            m  = (64'd1 << i) - 64'd1;
            ca = (64'h0000_00FF & m) + (64'h0000_0001 & m) + 64'd1;
            chk("chain_cin", 64'(slice_cin_o), (ca >> i) & 64'd1);
        end
        @(posedge clk);
        #1;

        // Reset mid-RUN at bit 15
        issue(32'hCAFE_F00D, 32'h1357_9BDF, 1'b0, 4'b0000, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_idle_zero("midrun_reset");
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b1, 4'b0000, 1'b0);

        // Randomized ops with random result backpressure
        rr_mode = 0;
        for (int k = 0; k < 40; k++) begin
            logic [3:0] s;
            s = 4'($urandom);
            issue($urandom, $urandom, 1'($urandom), s, s[3] ? 1'($urandom) : 1'b0);
        end

        // Drain
        rr_mode = 2;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives one 1-bit ALU slice LSB-first over WIDTH cycles and assembles a WIDTH-bit result with carry-out.
- Sits directly upstream and downstream of the slice: feeds its a/b/cin/sel inputs and consumes its f/cout outputs.
- Provides the area-minimal WIDTH-bit ALU alternative to the ripple-array build.
- Operand capture uses a start/ready handshake; result delivery uses a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range ≥2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- start_i  in  1  request; accepted on an edge where start_i && ready_o.
- ready_o  out  1  high only in IDLE.
- op_a_i  in  WIDTH  operand A, sampled on accept.
- op_b_i  in  WIDTH  operand B, sampled on accept.
- cin_i  in  1  carry-in, sampled on accept.
- sel_i  in  4  operation select, sampled on accept. [3:2]: 00 arith, 01 logic, 10 shr, 11 shl.
- slice_a_o  out  1  current A bit to slice.
- slice_b_o  out  1  current B bit to slice.
- slice_cin_o  out  1  carry register to slice.
- slice_sel_o  out  4  latched select to slice.
- slice_f_i  in  1  slice result bit.
- slice_cout_i  in  1  slice carry-out.
- result_o  out  WIDTH  assembled result.
- cout_o  out  1  final carry / shifted-out bit.
- valid_o  out  1  result valid; held until consumed.
- res_ready_i  in  1  consumer accepts result on an edge where valid_o && res_ready_i.

Behaviour:
- Reset (async assert, sync deassert at the next edge): state=IDLE.
  - Outputs: ready_o=1, valid_o=0, result_o=0, cout_o=0.
  - Slice drive: slice_*_o=0.
  - Internal: index=0, carry=0.
  - Reset mid-RUN or mid-DONE aborts the operation with no result.
- FSM IDLE→RUN on accept:
  - Latch op_a/op_b into shift registers; latch sel; carry←cin_i; index←0.
- RUN, one bit per cycle:
  - Slice drive is combinational from state: slice_a_o=A[index], slice_b_o=B[index], slice_cin_o=carry, slice_sel_o=latched sel.
  - Arith/logic bit capture: result bit[index]←slice_f_i and carry←slice_cout_i at each edge.
  - Shift ops are resolved in the controller; slice_f_i is ignored.
    - shr: bit[i]=A[i+1], bit[WIDTH-1]=0.
    - shl: bit[i]=A[i-1], bit[0]=0.
  - Slice is still driven during shifts.
  - index increments each edge.
  - Bits are shifted into result_o from the MSB side. result_o holds its old value until the DONE transition; a shadow register is allowed.
- RUN→DONE on the edge that captures bit WIDTH-1:
  - valid_o=1 exactly WIDTH cycles after the accept edge.
  - cout_o: arith/logic = last slice_cout_i; shr = A[0]; shl = A[WIDTH-1].
- DONE:
  - result_o and cout_o stable.
  - start_i is ignored (ready_o=0).
  - On valid_o && res_ready_i → IDLE: valid_o=0, ready_o=1 next cycle, result_o retained.
- Throughput: one op per WIDTH+2 cycles minimum (accept, WIDTH run cycles, consume).
- No back-to-back accept is permitted in the consume cycle.
- Operand changes on op_*_i/sel_i/cin_i outside the accept edge have no effect.
- res_ready_i asserted outside DONE has no effect.
- Slice outputs (slice_f_i, slice_cout_i) are sampled only in RUN.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- When defined:
  - Adds output zero_o (1 bit).
  - zero_o=1 iff the final result_o==0; updated on the RUN→DONE edge; held through IDLE until the next DONE.
  - zero_o resets to 0.
  - Computed incrementally: a sticky OR of captured bits, with no WIDTH-wide compare.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Add. Bench slice model for sel=0000 is a full adder (f=a^b^cin, cout=maj).
  - Stimulus: A=0xFFFF_FFFF, B=0x0000_0001, cin=0.
  - Response: valid_o 32 cycles after accept, result=0x0000_0000, cout=1; zero_o=1 if enabled.
- Shift right: sel=1000, A=0x8000_0001 → result=0x4000_0000, cout=1.
- Shift left: sel=1100, A=0x8000_0001 → result=0x0000_0002, cout=1.
  - Confirm slice_f_i is ignored by forcing it to 1 throughout.
- Backpressure and IDLE-only start:
  - Hold res_ready_i=0 for 10 cycles after valid → result/valid stable.
  - start_i pulsed in DONE → ignored.
  - Release res_ready_i → ready_o=1 next cycle.
- Reset mid-RUN: assert rst_ni low at bit 15 → immediate IDLE, all outputs 0.
  - New op after release (add 0x1234_5678+0x1111_1111, cin=1) → 0x2345_678A, cout=0.
- Carry chaining: add with A=0x0000_00FF, B=0x0000_0001, cin=1.
  - Check slice_cin_o per cycle = 1,1,1,1,1,1,1,1,1,0,…
  - Response: result=0x0000_0101, cout=0.
